// File: rtl/key_display_ctrl.sv
// key_display_ctrl: key-search status FSM driving six active-low 7-segment digits (spinner / key / blinking dash)
module hex7seg (
    input  logic [3:0] d,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h7F;
        case (d)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    end
endmodule

module key_display_ctrl #(
    parameter int TICK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clear,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [23:0] key,
    input  logic        key_found,
    output logic        busy,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    typedef enum logic [1:0] {IDLE, SEARCH, SHOW, FAIL} state_t;
    state_t state, state_nx;
    logic [23:0] key_reg;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic phase, xfer, moved, tick;
    logic [6:0] dig [6];
    logic [6:0] spin, dash;
    always_comb begin
        state_nx = state;
        key_ready = state == SEARCH && !clear;
        xfer = key_valid && key_ready;
        if (clear) state_nx = IDLE;
        else if (xfer) state_nx = key_found ? SHOW : FAIL;
        else if (start && state != SEARCH) state_nx = SEARCH;
    end
    assign busy = state == SEARCH;
    assign moved = state_nx != state;
    assign tick = !moved && cnt == LAST;
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            state <= IDLE;
            key_reg <= '0;
            cnt <= '0;
            idx <= '0;
            phase <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= (moved || cnt == LAST) ? '0 : cnt + CW'(1);
            if (xfer) key_reg <= key;
            if (moved && state_nx == SEARCH) idx <= '0;
            else if (tick && state == SEARCH) idx <= idx == 3'd5 ? 3'd0 : idx + 3'd1;
            if (moved && state_nx == FAIL) phase <= 1'b1;
            else if (tick && state == FAIL) phase <= ~phase;
        end
    end
    for (genvar n = 0; n < 6; n++) begin : g_dig
        hex7seg u_dec (.d(key_reg[4*n +: 4]), .seg(dig[n]));
    end
    assign spin = ~(7'd1 << idx);
    assign dash = phase ? 7'h3F : 7'h7F;
    always_comb begin
        HEX0 = state == SEARCH ? spin : state == SHOW ? dig[0] : state == FAIL ? dash : 7'h7F;
        HEX1 = state == SHOW ? dig[1] : state == FAIL ? dash : 7'h7F;
        HEX2 = state == SHOW ? dig[2] : state == FAIL ? dash : 7'h7F;
        HEX3 = state == SHOW ? dig[3] : state == FAIL ? dash : 7'h7F;
        HEX4 = state == SHOW ? dig[4] : state == FAIL ? dash : 7'h7F;
        HEX5 = state == SHOW ? dig[5] : state == FAIL ? dash : 7'h7F;
    end
endmodule

// File: tb/tb_key_display_ctrl.sv
// tb_key_display_ctrl: directed and random checks of key_display_ctrl against a mode/age reference model
module tb_key_display_ctrl;
    logic clk = 1'b0;
    logic rst, start, clear, key_valid, key_found, key_ready, busy;
    logic [23:0] key;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    int tests = 0;
    int fails = 0;
    // model: mode 0 idle, 1 search, 2 show, 3 fail; age = clocks spent in the current mode
    int mode, age;
    logic [23:0] mkey;
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    key_display_ctrl #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .key_valid(key_valid),
        .key_ready(key_ready), .key(key), .key_found(key_found), .busy(busy),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    always #5 clk = ~clk;

    function automatic logic [41:0] exp_hex();
        logic [41:0] e = {42{1'b1}};
        logic [6:0] spin = 7'h7F;
        for (int n = 0; n < 6; n++) begin
            if (mode == 2) e[7*n +: 7] = seg_tab[(mkey >> (4*n)) & 24'hF];
            if (mode == 3) e[7*n +: 7] = ((age / 4) % 2 == 0) ? 7'h3F : 7'h7F;
        end
        if (mode == 1) begin
            spin[(age / 4) % 6] = 1'b0;
            e[6:0] = spin;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [41:0] got, input logic [41:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_hex"}, {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, exp_hex());
        chk({tag, "_busy"}, 42'(busy), 42'(mode == 1));
        chk({tag, "_ready"}, 42'(key_ready), 42'(mode == 1));
    endtask

    task automatic cyc(input string tag, input logic s, input logic c, input logic kv,
                       input logic [23:0] k, input logic kf);
        int nm;
        start = s; clear = c; key_valid = kv; key = k; key_found = kf;
        @(posedge clk);
        nm = mode;
        if (c) begin
            nm = 0;
            mkey = '0;
        end else if (mode == 1 && kv) begin
            nm = kf ? 2 : 3;
            mkey = k;
        end else if (mode != 1 && s) nm = 1;
        age = (nm != mode || c) ? 0 : age + 1;
        mode = nm;
        #1;
        start = 0; clear = 0; key_valid = 0; key_found = 0;
        check_all(tag);
    endtask

    initial begin
        rst = 1; start = 0; clear = 0; key_valid = 0; key = '0; key_found = 0;
        mode = 0; age = 0; mkey = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        start = 1; key_valid = 1; key_found = 1; key = 24'h123456;
        @(posedge clk);
        #1;
        start = 0; key_valid = 0; key_found = 0;
        check_all("rst_holds_idle");
        rst = 0;
        cyc("idle_wait", 0, 0, 0, 0, 0);
        cyc("start", 1, 0, 0, 0, 0);
        chk("spin0", 42'(HEX0), 42'(7'b1111110));
        for (int i = 0; i < 4; i++) cyc("spin", 0, 0, 0, 0, 0);
        chk("spin1", 42'(HEX0), 42'(7'b1111101));
        for (int i = 0; i < 20; i++) cyc("spin", 0, 0, 0, 0, 0);
        chk("spin_wrap", 42'(HEX0), 42'(7'b1111110));
        cyc("start_in_search", 1, 0, 0, 0, 0);
        cyc("show", 0, 0, 1, 24'h0000A5, 1);
        chk("show_a5", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0},
            {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b0001000, 7'b0010010});
        cyc("show_ignore_kv", 0, 0, 1, 24'hFFFFFF, 1);
        chk("show_held", 42'(HEX0), 42'(7'b0010010));
        cyc("restart", 1, 0, 0, 0, 0);
        chk("restart_spin", 42'(HEX0), 42'(7'b1111110));
        cyc("fail", 0, 0, 1, 24'h00BEEF, 0);
        chk("fail_dash", 42'(HEX3), 42'(7'b0111111));
        for (int i = 0; i < 4; i++) cyc("blink", 0, 0, 0, 0, 0);
        chk("blink_off", 42'(HEX5), 42'(7'b1111111));
        for (int i = 0; i < 4; i++) cyc("blink", 0, 0, 0, 0, 0);
        chk("blink_on", 42'(HEX0), 42'(7'b0111111));
        cyc("fail_start", 1, 0, 0, 0, 0);
        #2 clear = 1;
        #1 chk("ready_clear", 42'(key_ready), 42'(0));
        clear = 0;
        cyc("clear_kv", 0, 1, 1, 24'h654321, 1);
        cyc("idle_kv", 0, 0, 1, 24'h111111, 1);
        cyc("start2", 1, 0, 0, 0, 0);
        cyc("search2", 0, 0, 0, 0, 0);
        #3 rst = 1;
        #1;
        mode = 0; age = 0; mkey = '0;
        check_all("async_rst");
        @(posedge clk);
        #1 rst = 0;
        check_all("after_rst");
        for (int i = 0; i < 400; i++)
            cyc("rand", $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 4) == 0, 24'($urandom), 1'($urandom_range(0, 1)));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/key_display_ctrl.md
KEY_DISPLAY_CTRL -- requirements
Module: key_display_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, the number of clk cycles per animation/blink tick (minimum 2).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, a single-cycle pulse meaning a key search has begun.
REQ-005 SHALL have port clear, input, 1, a level that returns the display to blank.
REQ-006 SHALL have port key_valid, input, 1, meaning the search result is presented.
REQ-007 SHALL have port key_ready, output, 1, meaning the controller accepts a result.
REQ-008 SHALL have port key, input, 24, the result key value.
REQ-009 SHALL have port key_found, input, 1, where 1 means the key is valid and 0 means no key exists.
REQ-010 SHALL have port busy, output, 1, high while in SEARCH.
REQ-011 SHALL have ports HEX0..HEX5, output, 7 each, active-low segment patterns with bit0 = segment a.

Function
REQ-012 SHALL implement four states: IDLE, SEARCH, SHOW and FAIL.
REQ-013 SHALL give transitions the priority rst > clear > key handshake > start.
  - clear in any state: -> IDLE.
  - IDLE + start: -> SEARCH.
  - SEARCH + key_valid & key_found: -> SHOW.
  - SEARCH + key_valid & !key_found: -> FAIL.
  - SHOW/FAIL + start: -> SEARCH.
  - start in SEARCH: ignored.
REQ-014 SHALL drive key_ready = 1 only in SEARCH with clear low; a transfer occurs on the edge where key_valid & key_ready are both high.
REQ-015 SHALL latch key into a 24-bit register and key_found into the state at the transfer edge; the key is held until the next transfer.
REQ-016 SHALL ignore key_valid outside SEARCH, with no latch and no state change.
REQ-017 SHALL run a tick counter 0..TICK_DIV-1 that emits a one-cycle tick when it wraps from TICK_DIV-1 to 0.
  - Counter forced to 0 on every state transition.
REQ-018 SHALL keep a 3-bit spinner index.
  - Set to 0 on entry to SEARCH.
  - On each tick in SEARCH: index+1, wrapping 5 -> 0.
  - Values 6-7 unreachable.
REQ-019 SHALL keep a blink phase bit.
  - Set to 1 (visible) on entry to FAIL.
  - Toggles on each tick in FAIL.
REQ-020 SHALL drive outputs by state, all combinational from registers (no extra latency).
  - IDLE: all HEX = 1111111.
  - SEARCH: HEX0 = all ones with bit[index] = 0; HEX1..HEX5 = 1111111.
  - SHOW: HEXn = hex7seg(key_reg[4n+3:4n]), via six instances of the team's hex7seg decoder.
  - FAIL: all HEX = 0111111 (dash) when phase = 1, else 1111111.
REQ-021 SHALL make the new state's outputs visible in the cycle immediately after the transition edge.
REQ-022 SHALL clear counter, index, phase and key_reg when clear is taken, same as reset.

Reset
REQ-023 SHALL, on rst high (asynchronously, also mid-operation): state = IDLE, key_reg = 0, counter = 0, index = 0, phase = 0, key_ready = 0, busy = 0, all HEX = 1111111.
REQ-024 SHALL ignore start, clear and key_valid while rst is high, and leave IDLE only on a start after rst deasserts.

Verification
REQ-025 SHALL cover: TICK_DIV=4, start pulse -> busy = 1, HEX0 = 1111110 next cycle, HEX0 = 1111101 after 4 clks; after 24 clks index is back at 0.
REQ-026 SHALL cover: in SEARCH, key = 0x0000A5 with key_found = 1 and key_valid for 1 clk -> HEX0 = hex7seg(5) = 0010010, HEX1 = hex7seg(A) = 0001000, HEX2..HEX5 = hex7seg(0) = 1000000, key_ready = 0.
REQ-027 SHALL cover: in SEARCH, key_valid with key_found = 0 -> all HEX = 0111111; with TICK_DIV=4, all 1111111 after 4 clks and dash again after 8 clks.
REQ-028 SHALL cover: in SHOW, key_valid = 1 with a new key = 0xFFFFFF -> display unchanged; then start -> SEARCH, HEX0 = 1111110.
REQ-029 SHALL cover: clear and key_valid asserted together in SEARCH -> IDLE, all HEX = 1111111, key_reg = 0.
REQ-030 SHALL cover: rst asserted mid-SEARCH between clock edges -> outputs all 1111111 and busy = 0 immediately, without waiting for a clock edge.
